// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI responder.
//   SPI_BITS      - bits per SPI byte.
//   SPI_IDLE_FILL - default byte shifted out when no TX byte is pending.
//   spi_state_t   - responder FSM state encoding.
//   next_tx_byte  - selects the byte loaded into the output shifter.
package spi_pkg;

  localparam int SPI_BITS = 8;
  localparam int SPI_CNT_W = $clog2(SPI_BITS);
  localparam logic [SPI_BITS-1:0] SPI_IDLE_FILL = 8'hFF;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_t;

  // A pending holding byte wins; otherwise the idle fill pattern goes out.
  function automatic logic [SPI_BITS-1:0] next_tx_byte(
    input logic                busy,
    input logic [SPI_BITS-1:0] hold,
    input logic [SPI_BITS-1:0] fill
  );
    return busy ? hold : fill;
  endfunction

endpackage

// File: rtl/spi_responder_if.sv
// spi_responder_if: CPU-side register interface of the SPI responder.
//   wr/tx_data/busy      - TX holding register write strobe, data, full flag.
//   rd/rx_data/valid     - RX acknowledge strobe, last byte, unread flag.
//   overrun              - sticky RX overrun flag.
//   selected             - synchronized chip-select status.
// Modports: master = CPU side, slave = responder.
interface spi_responder_if;

  logic                          wr;
  logic [spi_pkg::SPI_BITS-1:0]  tx_data;
  logic                          busy;
  logic                          rd;
  logic [spi_pkg::SPI_BITS-1:0]  rx_data;
  logic                          valid;
  logic                          overrun;
  logic                          selected;

  modport master (
    output wr, tx_data, rd,
    input  busy, rx_data, valid, overrun, selected
  );

  modport slave (
    input  wr, tx_data, rd,
    output busy, rx_data, valid, overrun, selected
  );

endinterface

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous pin with
// registered rise/fall pulses.
//   clk, reset - system clock, synchronous active-high reset.
//   d          - asynchronous input pin.
//   q          - synchronized level, time-aligned with rise/fall.
//   rise, fall - one-cycle pulses, STAGES+1 clk after the pin edge.
// RESET_VAL should match the pin's idle level so that leaving reset does
// not produce a spurious edge.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stage_reg;
  logic              prev_reg;
  logic              rise_reg;
  logic              fall_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) stage_reg[gi] <= RESET_VAL;
          else       stage_reg[gi] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset) stage_reg[gi] <= RESET_VAL;
          else       stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  // The extra flop both gives the previous sample for edge detection and
  // keeps q aligned with the registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg <= RESET_VAL;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      prev_reg <= stage_reg[STAGES-1];
      rise_reg <= stage_reg[STAGES-1] & ~prev_reg;
      fall_reg <= ~stage_reg[STAGES-1] & prev_reg;
    end
  end

  assign q    = prev_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/spi_responder.sv
// spi_responder: byte-oriented SPI responder (mode 0, MSB first) polled by
// the CPU through a UART-like register interface.
//   clk, reset    - system clock, synchronous active-high reset.
//   sck/cs_n/mosi - asynchronous SPI pins from the external master.
//   miso, miso_oe - registered responder data and pad output enable.
//   bus           - CPU side (wr/tx_data/busy, rd/rx_data/valid, overrun,
//                   selected).
module spi_responder
  import spi_pkg::*;
#(
  parameter int                  SYNC_STAGES = 2,
  parameter logic [SPI_BITS-1:0] IDLE_FILL   = SPI_IDLE_FILL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  spi_responder_if.slave        bus
);

  // Pin index 0 = sck, 1 = cs_n, 2 = mosi. cs_n idles high.
  localparam logic [2:0] PIN_RESET = 3'b010;

  logic [2:0] pin_vec;
  logic [2:0] pin_q;
  logic [2:0] pin_rise;
  logic [2:0] pin_fall;

  assign pin_vec = {mosi, cs_n, sck};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (PIN_RESET[gi])
      ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pin_vec[gi]),
        .q     (pin_q[gi]),
        .rise  (pin_rise[gi]),
        .fall  (pin_fall[gi])
      );
    end
  endgenerate

  logic sck_rise, sck_fall, cs_rise, cs_fall, cs_s, mosi_s;
  assign sck_rise = pin_rise[0];
  assign sck_fall = pin_fall[0];
  assign cs_rise  = pin_rise[1];
  assign cs_fall  = pin_fall[1];
  assign cs_s     = pin_q[1];
  assign mosi_s   = pin_q[2];

  // Level of sck and edges of mosi are not needed by the protocol logic.
  logic unused_pins;
  assign unused_pins = &{1'b0, pin_q[0], pin_rise[2], pin_fall[2]};

  spi_state_t           state_reg,     state_next;
  logic [SPI_CNT_W-1:0] bit_cnt_reg,   bit_cnt_next;
  logic [SPI_BITS-1:0]  shift_in_reg,  shift_in_next;
  logic [SPI_BITS-1:0]  shift_out_reg, shift_out_next;
  logic                 miso_reg,      miso_next;
  logic                 miso_oe_reg,   miso_oe_next;
  logic [SPI_BITS-1:0]  tx_hold_reg,   tx_hold_next;
  logic                 busy_reg,      busy_next;
  logic [SPI_BITS-1:0]  rx_data_reg,   rx_data_next;
  logic                 valid_reg,     valid_next;
  logic                 overrun_reg,   overrun_next;
  logic                 selected_reg;

  logic                 load_tx;
  logic                 byte_done;
  logic [SPI_BITS-1:0]  captured;
  logic [SPI_BITS-1:0]  load_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= SPI_IDLE;
      bit_cnt_reg   <= '0;
      shift_in_reg  <= '0;
      shift_out_reg <= '0;
      miso_reg      <= 1'b0;
      miso_oe_reg   <= 1'b0;
      tx_hold_reg   <= '0;
      busy_reg      <= 1'b0;
      rx_data_reg   <= '0;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
      selected_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_in_reg  <= shift_in_next;
      shift_out_reg <= shift_out_next;
      miso_reg      <= miso_next;
      miso_oe_reg   <= miso_oe_next;
      tx_hold_reg   <= tx_hold_next;
      busy_reg      <= busy_next;
      rx_data_reg   <= rx_data_next;
      valid_reg     <= valid_next;
      overrun_reg   <= overrun_next;
      selected_reg  <= ~cs_s;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_in_next  = shift_in_reg;
    shift_out_next = shift_out_reg;
    miso_next      = miso_reg;
    miso_oe_next   = miso_oe_reg;
    tx_hold_next   = tx_hold_reg;
    busy_next      = busy_reg;
    rx_data_next   = rx_data_reg;
    valid_next     = valid_reg;
    overrun_next   = overrun_reg;
    load_tx        = 1'b0;
    byte_done      = 1'b0;
    captured       = {shift_in_reg[SPI_BITS-2:0], mosi_s};
    load_byte      = next_tx_byte(busy_reg, tx_hold_reg, IDLE_FILL);

    case (state_reg)
      SPI_IDLE: begin
        if (cs_fall) begin
          state_next   = SPI_ACTIVE;
          bit_cnt_next = '0;
          miso_oe_next = 1'b1;
          load_tx      = 1'b1;
        end
      end
      SPI_ACTIVE: begin
        if (cs_rise) begin
          // Partial byte is dropped; the holding register is untouched.
          state_next   = SPI_IDLE;
          miso_oe_next = 1'b0;
          bit_cnt_next = '0;
        end else begin
          if (sck_rise) begin
            shift_in_next = captured;
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            byte_done     = (bit_cnt_reg == SPI_CNT_W'(SPI_BITS - 1));
          end
          if (sck_fall) begin
            // bit_cnt has already wrapped to 0 after the 8th rise, so the
            // falling edge that follows starts the next byte.
            if (bit_cnt_reg == '0) begin
              load_tx = 1'b1;
            end else begin
              shift_out_next = {shift_out_reg[SPI_BITS-2:0], 1'b0};
              miso_next      = shift_out_reg[SPI_BITS-2];
            end
          end
        end
      end
      default: state_next = SPI_IDLE;
    endcase

    if (load_tx) begin
      shift_out_next = load_byte;
      miso_next      = load_byte[SPI_BITS-1];
      busy_next      = 1'b0;
    end

    if (bus.rd) valid_next = 1'b0;

    // An rd in the completion cycle frees the register for the new byte.
    if (byte_done) begin
      if (valid_reg && !bus.rd) begin
        overrun_next = 1'b1;
      end else begin
        rx_data_next = captured;
        valid_next   = 1'b1;
      end
    end

    // busy_reg is the pre-load value, so a write colliding with a load is
    // ignored when the holding register was full.
    if (bus.wr && !busy_reg) begin
      tx_hold_next = bus.tx_data;
      busy_next    = 1'b1;
    end
  end

  assign miso         = miso_reg;
  assign miso_oe      = miso_oe_reg;
  assign bus.busy     = busy_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.valid    = valid_reg;
  assign bus.overrun  = overrun_reg;
  assign bus.selected = selected_reg;

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: self-checking bench for spi_responder. A bit-banged
// mode-0 master runs at clk/16; expected MISO bytes go through a queue.
module tb_spi_responder;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic sck, cs_n, mosi;
  logic miso, miso_oe;

  spi_responder_if bus ();

  spi_responder #(
    .SYNC_STAGES (2),
    .IDLE_FILL   (8'hFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sck     (sck),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    bit         has_wr;
    logic [7:0] wr_data;
    logic [7:0] mosi_byte;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [7:0] d);
    bus.tx_data = d;
    bus.wr      = 1'b1;
    tick(1);
    bus.wr      = 1'b0;
  endtask

  task automatic cpu_ack();
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
  endtask

  // Clocks nbits bits MSB first. Optional hooks on the 8th bit: rd pulsed
  // in the completion cycle, or an ack / write while sck is still high.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits,
                          input bit rd_at_done, input bit mid_ack,
                          input bit mid_wr, input logic [7:0] wr_data,
                          output logic [7:0] mi);
    bit last;
    mi   = '0;
    mosi = mo[7];
    for (int b = 0; b < nbits; b++) begin
      last = (b == 7);
      sck = 1'b1;
      mi[7-b] = miso;
      if (last && rd_at_done) begin
        tick(3);
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        tick(4);
      end else begin
        tick(8);
      end
      if (last && mid_ack) begin
        check("mid_valid", bus.valid, 1);
        check("mid_rx", bus.rx_data, mo);
        cpu_ack();
      end
      if (last && mid_wr) cpu_write(wr_data);
      sck = 1'b0;
      if (b < 7) mosi = mo[6-b];
      tick(8);
    end
  endtask

  task automatic byte_sb(input string tag, input logic [7:0] mo,
                         input bit rd_at_done, input bit mid_ack,
                         input bit mid_wr, input logic [7:0] wr_data);
    logic [7:0] mi;
    logic [7:0] e;
    spi_xfer(mo, 8, rd_at_done, mid_ack, mid_wr, wr_data, mi);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no expected byte queued, got miso=%h", tag, mi);
    end else begin
      e = exp_q.pop_front();
      check(tag, mi, e);
    end
    $display("xfer %s: mosi=%h miso=%h rx_data=%h valid=%0d overrun=%0d",
             tag, mo, mi, bus.rx_data, bus.valid, bus.overrun);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_miso"},     miso,         0);
    check({tag, "_miso_oe"},  miso_oe,      0);
    check({tag, "_busy"},     bus.busy,     0);
    check({tag, "_valid"},    bus.valid,    0);
    check({tag, "_overrun"},  bus.overrun,  0);
    check({tag, "_selected"}, bus.selected, 0);
    check({tag, "_rx_data"},  bus.rx_data,  8'h00);
  endtask

  initial begin
    logic [7:0] mi;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b1, 8'h96, 8'hC3, 8'h96, 8'hC3};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 8'h01, 8'hFF, 8'h01, 8'hFF};

    reset = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.tx_data = 8'h00;
    tick(5);
    check_reset_state("por");
    reset = 1'b0;
    tick(8);

    // Single-byte exchanges from the table.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].has_wr) begin
        cpu_write(vecs[i].wr_data);
        check("vec_busy_set", bus.busy, 1);
      end
      exp_q.push_back(vecs[i].exp_miso);
      cs_n = 1'b0;
      tick(8);
      check("vec_busy_clr", bus.busy, 0);
      check("vec_selected", bus.selected, 1);
      check("vec_miso_oe", miso_oe, 1);
      byte_sb("vec_miso", vecs[i].mosi_byte, 0, 0, 0, 8'h00);
      cs_n = 1'b1;
      tick(8);
      check("vec_valid", bus.valid, 1);
      check("vec_rx", bus.rx_data, vecs[i].exp_rx);
      check("vec_oe_off", miso_oe, 0);
      cpu_ack();
      check("vec_valid_clr", bus.valid, 0);
    end

    // wr while busy is ignored; rd exactly at completion avoids overrun.
    cpu_write(8'h5C);
    cpu_write(8'h99);
    check("wr_busy_held", bus.busy, 1);
    exp_q.push_back(8'h5C);
    exp_q.push_back(8'hFF);
    cs_n = 1'b0;
    tick(8);
    byte_sb("coin_b0", 8'h33, 0, 0, 0, 8'h00);
    check("coin_rx0", bus.rx_data, 8'h33);
    byte_sb("coin_b1", 8'h44, 1, 0, 0, 8'h00);
    check("coin_valid", bus.valid, 1);
    check("coin_rx1", bus.rx_data, 8'h44);
    check("coin_overrun", bus.overrun, 0);
    cs_n = 1'b1;
    tick(8);
    cpu_ack();

    // Back-to-back TX: second byte written before the 8th falling edge.
    cpu_write(8'h11);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    cs_n = 1'b0;
    tick(8);
    byte_sb("b2b_b0", 8'h10, 0, 1, 1, 8'h22);
    byte_sb("b2b_b1", 8'h20, 0, 1, 0, 8'h00);
    cs_n = 1'b1;
    tick(8);
    check("b2b_busy", bus.busy, 0);

    // Abort after 5 bits, then a clean transfer.
    cs_n = 1'b0;
    tick(8);
    spi_xfer(8'hB7, 5, 0, 0, 0, 8'h00, mi);
    cs_n = 1'b1;
    tick(8);
    $display("xfer abort: 5 bits mosi=B7 miso_bits=%h", mi[7:3]);
    check("abort_valid", bus.valid, 0);
    check("abort_oe", miso_oe, 0);
    cpu_write(8'hE1);
    exp_q.push_back(8'hE1);
    cs_n = 1'b0;
    tick(8);
    byte_sb("abort_next", 8'h6D, 0, 1, 0, 8'h00);
    cs_n = 1'b1;
    tick(8);

    // Idle fill over two bytes without rd: second byte overruns.
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    cs_n = 1'b0;
    tick(8);
    byte_sb("fill_b0", 8'h01, 0, 0, 0, 8'h00);
    check("fill_rx0", bus.rx_data, 8'h01);
    check("fill_valid0", bus.valid, 1);
    check("fill_ovr0", bus.overrun, 0);
    byte_sb("fill_b1", 8'h02, 0, 0, 0, 8'h00);
    check("fill_ovr1", bus.overrun, 1);
    check("fill_rx1", bus.rx_data, 8'h01);
    cs_n = 1'b1;
    tick(8);

    // Reset after 3 bits with busy, valid and overrun all set.
    cs_n = 1'b0;
    tick(8);
    spi_xfer(8'hC9, 3, 0, 0, 0, 8'h00, mi);
    cpu_write(8'h77);
    check("rst_pre_busy", bus.busy, 1);
    check("rst_pre_oe", miso_oe, 1);
    reset = 1'b1;
    tick(1);
    $display("xfer reset: 3 bits mosi=C9 then reset");
    check_reset_state("midrst");
    cs_n = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(8);
    cpu_write(8'hA6);
    exp_q.push_back(8'hA6);
    cs_n = 1'b0;
    tick(8);
    byte_sb("rst_next", 8'h5A, 0, 1, 0, 8'h00);
    cs_n = 1'b1;
    tick(8);
    check("rst_next_ovr", bus.overrun, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
